// File: rtl/clk_div_cfg_ctrl.sv
// Configuration front-end for the integer clock divider: accepts ratio/enable
// requests and applies them with the divider enable dropped around every ratio change.
module clk_div_cfg_ctrl #(
   parameter int RATIO_W       = 4,
   parameter int SETTLE_CYC    = 2,
   parameter int DEFAULT_RATIO = 1
) (
   input  logic               i_ref_clk,
   input  logic               i_rst,
   input  logic               i_cfg_valid,
   input  logic [RATIO_W-1:0] i_cfg_ratio,
   input  logic               i_cfg_enable,
   output logic               o_cfg_ready,
   output logic [RATIO_W-1:0] o_div_ratio,
   output logic               o_clk_enable,
   output logic               o_busy,
   output logic               o_cfg_err,
   output logic [1:0]         o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUIESCE = 2'd1,
      RESUME  = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

   state_t             state;
   logic [3:0]         cnt;
   logic [RATIO_W-1:0] held_ratio;
   logic               held_en;
   logic               accept;
   logic               eff_en;

   // Handshake: a request transfers on a rising edge with i_cfg_valid and
   // o_cfg_ready both high; the requester keeps it stable until then.
   assign accept      = i_cfg_valid && o_cfg_ready;
   // Ratio 1 is bypass, so the divider is never enabled for it.
   assign eff_en      = i_cfg_enable && (i_cfg_ratio >= RATIO_W'(2));
   assign o_dbg_state = state;

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         held_ratio   <= '0;
         held_en      <= 1'b0;
         o_div_ratio  <= RATIO_W'(DEFAULT_RATIO);
         o_clk_enable <= 1'b0;
         o_busy       <= 1'b0;
         o_cfg_err    <= 1'b0;
         o_cfg_ready  <= 1'b1;
      end else begin
         o_cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (i_cfg_ratio == '0) begin
                     o_cfg_err <= 1'b1;
                  end else if (i_cfg_ratio == o_div_ratio) begin
                     o_clk_enable <= eff_en;
                  end else begin
                     held_ratio   <= i_cfg_ratio;
                     held_en      <= eff_en;
                     o_clk_enable <= 1'b0;
                     o_busy       <= 1'b1;
                     o_cfg_ready  <= 1'b0;
                     cnt          <= '0;
                     state        <= QUIESCE;
                  end
               end
            end
            QUIESCE: begin
               if (cnt == LAST_CNT) begin
                  o_div_ratio <= held_ratio;
                  cnt         <= '0;
                  state       <= RESUME;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RESUME: begin
               if (cnt == LAST_CNT) begin
                  o_clk_enable <= held_en;
                  o_busy       <= 1'b0;
                  o_cfg_ready  <= 1'b1;
                  state        <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: directed requests push time-stamped output
// snapshots; a negedge monitor pops one whenever the outputs change.
module tb_clk_div_cfg_ctrl;

   localparam int S = 2;
   localparam int W = 40;
   localparam int K_FULL = 0, K_FAST = 1, K_REJ = 2, K_ABORT = 3;

   logic       clk;
   logic       rst;
   logic       i_cfg_valid;
   logic [3:0] i_cfg_ratio;
   logic       i_cfg_enable;
   logic       o_cfg_ready;
   logic [3:0] o_div_ratio;
   logic       o_clk_enable;
   logic       o_busy;
   logic       o_cfg_err;
   logic [1:0] o_dbg_state;

   clk_div_cfg_ctrl #(.RATIO_W(4), .SETTLE_CYC(S), .DEFAULT_RATIO(1)) dut (
      .i_ref_clk   (clk),
      .i_rst       (rst),
      .i_cfg_valid (i_cfg_valid),
      .i_cfg_ratio (i_cfg_ratio),
      .i_cfg_enable(i_cfg_enable),
      .o_cfg_ready (o_cfg_ready),
      .o_div_ratio (o_div_ratio),
      .o_clk_enable(o_clk_enable),
      .o_busy      (o_busy),
      .o_cfg_err   (o_cfg_err),
      .o_dbg_state (o_dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   logic [3:0] cur_r  = 4'd1;
   logic       cur_en = 1'b0;
   bit         mon_on = 0;

   // snapshot: {edge stamp, ratio, enable, busy, ready, err}
   function automatic logic [W-1:0] mk(input int st, input logic [3:0] r, input logic en,
                                        input logic b, input logic rdy, input logic err);
      return {32'(st), r, en, b, rdy, err};
   endfunction

   // scoreboard monitor
   logic [7:0] prev_snap = '0;
   always @(negedge clk) begin
      logic [7:0]   snap;
      logic [W-1:0] act, e;
      snap = {o_div_ratio, o_clk_enable, o_busy, o_cfg_ready, o_cfg_err};
      act  = {32'(edge_n), snap};
      if (mon_on && snap != prev_snap) begin
         if (snap[7:4] != prev_snap[7:4]) begin
            total++;
            if (snap[3] || prev_snap[3]) begin
               bad++;
               $display("FAIL ratio_while_enabled: ratio %0d->%0d with enable %0b->%0b at edge %0d",
                        prev_snap[7:4], snap[7:4], prev_snap[3], snap[3], edge_n);
            end
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: got edge=%0d ratio=%0d en=%0b busy=%0b rdy=%0b err=%0b, expected no change",
                     edge_n, snap[7:4], snap[3], snap[2], snap[1], snap[0]);
         end else begin
            e = exp_q.pop_front();
            if (e !== act)
               $display("FAIL snapshot: got edge=%0d ratio=%0d en=%0b busy=%0b rdy=%0b err=%0b, expected edge=%0d ratio=%0d en=%0b busy=%0b rdy=%0b err=%0b",
                        act[39:8], act[7:4], act[3], act[2], act[1], act[0],
                        e[39:8], e[7:4], e[3], e[2], e[1], e[0]);
            if (e !== act) bad++;
         end
      end
      prev_snap = snap;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // driver: call at posedge+1; returns at E0+1 with the request withdrawn
   task automatic req(input logic [3:0] r, input logic en, input int kind,
                      input logic [3:0] er, input logic ee, output int e0);
      logic rdy;
      bit   acc;
      acc = 0;
      e0  = -1;
      i_cfg_ratio  = r;
      i_cfg_enable = en;
      i_cfg_valid  = 1'b1;
      for (int i = 0; i < 40 && !acc; i++) begin
         rdy = o_cfg_ready;
         @(posedge clk);
         #1;
         if (rdy) acc = 1;
      end
      i_cfg_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: ratio=%0d not accepted within 40 cycles, expected acceptance", r);
         return;
      end
      e0 = edge_n;
      case (kind)
         K_REJ: begin
            exp_q.push_back(mk(e0, cur_r, cur_en, 1'b0, 1'b1, 1'b1));
            exp_q.push_back(mk(e0 + 1, cur_r, cur_en, 1'b0, 1'b1, 1'b0));
         end
         K_FAST: begin
            if (ee != cur_en) exp_q.push_back(mk(e0, cur_r, ee, 1'b0, 1'b1, 1'b0));
         end
         K_ABORT: begin
            exp_q.push_back(mk(e0, cur_r, 1'b0, 1'b1, 1'b0, 1'b0));
         end
         default: begin
            exp_q.push_back(mk(e0, cur_r, 1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(e0 + S, er, 1'b0, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(mk(e0 + 2 * S, er, ee, 1'b0, 1'b1, 1'b0));
         end
      endcase
      cur_r  = er;
      cur_en = ee;
   endtask

   initial begin
      int e0, e0b;
      rst          = 1'b1;
      i_cfg_valid  = 1'b0;
      i_cfg_ratio  = 4'd0;
      i_cfg_enable = 1'b0;
      wait_cyc(3);
      check("reset_ratio", 32'(o_div_ratio), 32'd1);
      check("reset_enable", 32'(o_clk_enable), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_ready", 32'(o_cfg_ready), 32'd1);
      check("reset_err", 32'(o_cfg_err), 32'd0);
      mon_on = 1;
      rst    = 1'b0;
      wait_cyc(2);

      // full change, running ratio change, fast path, bypass, rejection
      req(4'd4, 1'b1, K_FULL, 4'd4, 1'b1, e0);  wait_cyc(2 * S + 2);
      req(4'd7, 1'b1, K_FULL, 4'd7, 1'b1, e0);  wait_cyc(2 * S + 2);
      req(4'd7, 1'b0, K_FAST, 4'd7, 1'b0, e0);  wait_cyc(3);
      req(4'd1, 1'b1, K_FULL, 4'd1, 1'b0, e0);  wait_cyc(2 * S + 2);
      req(4'd0, 1'b1, K_REJ,  4'd1, 1'b0, e0);  wait_cyc(3);
      req(4'd6, 1'b0, K_FULL, 4'd6, 1'b0, e0);  wait_cyc(2 * S + 2);
      req(4'd6, 1'b1, K_FAST, 4'd6, 1'b1, e0);  wait_cyc(3);

      // back-to-back: second request held through the busy window
      req(4'd3, 1'b1, K_FULL, 4'd3, 1'b1, e0);
      req(4'd9, 1'b1, K_FULL, 4'd9, 1'b1, e0b);
      check("b2b_spacing", 32'(e0b - e0), 32'(2 * S + 1));
      wait_cyc(2 * S + 2);

      // reset one edge after acceptance; request is discarded
      req(4'd5, 1'b1, K_ABORT, 4'd5, 1'b1, e0);
      @(posedge clk);
      #2;
      exp_q.push_back(mk(edge_n, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0));
      rst = 1'b1;
      #1;
      check("async_rst_ratio", 32'(o_div_ratio), 32'd1);
      check("async_rst_enable", 32'(o_clk_enable), 32'd0);
      check("async_rst_ready", 32'(o_cfg_ready), 32'd1);
      check("async_rst_busy", 32'(o_busy), 32'd0);
      cur_r  = 4'd1;
      cur_en = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_cyc(3);

      // sweep every enabling ratio
      for (int r = 2; r <= 15; r++) begin
         req(4'(r), 1'b1, K_FULL, 4'(r), 1'b1, e0);
         wait_cyc(2 * S + 1);
         check("sweep_ratio", 32'(o_div_ratio), 32'(r));
      end
      wait_cyc(4);
      check("final_enable", 32'(o_clk_enable), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
- Configuration front-end placed directly upstream of the integer clock divider; owns the divider's i_div_ratio and i_clk_enable inputs.
- Accepts ratio/enable requests over a valid/ready handshake, then sequences them onto the divider glitch-safely.
- Sequence per change: drop the divider enable, wait, change the ratio, wait, restore the enable.
- All logic runs in the divider's reference clock domain.

Parameters:
- RATIO_W, 4: width of the division ratio bus; matches the divider's ratio input.
- SETTLE_CYC, 2: i_ref_clk cycles spent in each of the QUIESCE and RESUME phases; legal range 1..15.
- DEFAULT_RATIO, 1: o_div_ratio value after reset; 1 means divider bypass.

Ports:
- i_ref_clk  in  1  reference clock; the same clock the divider uses.
- i_rst  in  1  asynchronous, active-high reset.
- i_cfg_valid  in  1  configuration request valid.
- i_cfg_ratio  in  RATIO_W  requested division ratio.
- i_cfg_enable  in  1  requested divider enable.
- o_cfg_ready  out  1  controller can accept a request.
- o_div_ratio  out  RATIO_W  ratio driven to the divider.
- o_clk_enable  out  1  enable driven to the divider.
- o_busy  out  1  a change sequence is in progress.
- o_cfg_err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Clock and reset: one clock (i_ref_clk); reset i_rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: o_div_ratio=DEFAULT_RATIO, o_clk_enable=0, o_busy=0, o_cfg_err=0, o_cfg_ready=1, state=IDLE, counter=0, held request=0.
- Reset asserted mid-sequence returns every output to its reset value immediately. The in-flight request is discarded.
- Handshake: a request is accepted on a rising edge where i_cfg_valid=1 and o_cfg_ready=1. Call that edge E0.
  - o_cfg_ready is high only in IDLE.
  - While busy, the requester holds i_cfg_valid and i_cfg_ratio/i_cfg_enable stable; the controller never drops a held request.
- Effective enable: eff_en = i_cfg_enable AND (ratio >= 2). Ratio 1 is accepted but always forces the enable to 0 (divider bypass).
- Rejection: an accepted request with i_cfg_ratio=0 gives o_cfg_err=1 for exactly the cycle after E0. There is no other state or output change, and o_cfg_ready stays 1.
- Fast path: an accepted request with i_cfg_ratio == o_div_ratio gives o_clk_enable <= eff_en at E0. The FSM stays in IDLE and o_busy stays 0.
- Full path: an accepted request with a different nonzero ratio runs the sequence below.
  - At E0: latch ratio and eff_en; o_clk_enable<=0, o_busy<=1, o_cfg_ready<=0; state->QUIESCE; counter<=0.
  - QUIESCE: counter increments each cycle. On the edge where the counter reaches SETTLE_CYC-1, o_div_ratio<=latched ratio (edge E0+SETTLE_CYC); state->RESUME; counter<=0.
  - RESUME: counter increments. On the edge where it reaches SETTLE_CYC-1 (edge E0+2*SETTLE_CYC): o_clk_enable<=latched eff_en, o_busy<=0, o_cfg_ready<=1; state->IDLE.
- Invariants:
  - o_div_ratio never changes while o_clk_enable=1.
  - o_clk_enable is 0 for at least SETTLE_CYC cycles on each side of a ratio change.
- Back-to-back: a request held during busy is accepted on the first edge with ready high, which is the edge after returning to IDLE. This gives minimum spacing of 2*SETTLE_CYC+1 cycles between full-path accepts.
- Ratio values up to 2^RATIO_W-1 are passed unmodified. There is no arithmetic on the ratio beyond the equality and >=2 compares.

Test Plan:
- Reset check: assert i_rst mid-cycle, asynchronously -> outputs go to ratio=1, enable=0, busy=0, ready=1 immediately, with no clock edge needed.
- Full change, SETTLE_CYC=2: from reset, request ratio=4, enable=1 at E0 -> o_div_ratio=4 at E0+2; o_clk_enable=1 and ready=1 at E0+4; busy high over E0..E0+4.
- Ratio change while running: with ratio=4 and enable=1, request ratio=7, enable=1 -> enable low from E0; ratio 7 at E0+2; enable high at E0+4. Check ratio never changes while enable=1.
- Fast path and bypass:
  - With ratio=7, request ratio=7, enable=0 -> enable=0 at E0, busy never asserts.
  - Then request ratio=1, enable=1 -> full sequence ends with ratio=1, enable=0.
- Rejection: request ratio=0 -> o_cfg_err high for exactly one cycle; ratio and enable unchanged; ready stays 1.
- Back-to-back and reset mid-sequence:
  - Hold valid with ratio=9 during a busy sequence -> accepted one cycle after ready returns.
  - Assert i_rst at E0+1 of a sequence -> ratio=1, enable=0, ready=1; the request is lost.
  - Sweep ratios 2..15 -> the final o_div_ratio matches each request.
